// File: rtl/addsub_operand_stage.sv
// Two-entry operand-issue buffer feeding the 32-bit carry-select adder; decodes ADD/SUB/INC/NEG at push.
// Optional ADDSUB_STALL_STATS_EN adds a saturating stall_count output.
module addsub_operand_stage #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 2
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [1:0]       in_op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] add_in1,
    output logic [WIDTH-1:0] add_in2,
    output logic             add_cin,
    output logic [1:0]       out_op,
    output logic [15:0]      op_count
`ifdef ADDSUB_STALL_STATS_EN
    ,
    output logic [15:0]      stall_count
`endif
);

    localparam logic [1:0] FULL = 2'(DEPTH);

    typedef enum logic [1:0] {
        OP_ADD = 2'b00,
        OP_SUB = 2'b01,
        OP_INC = 2'b10,
        OP_NEG = 2'b11
    } op_e;

    logic [WIDTH-1:0] mem_in1 [2];
    logic [WIDTH-1:0] mem_in2 [2];
    logic             mem_cin [2];
    logic [1:0]       mem_op  [2];

    logic       head;
    logic       tail;
    logic [1:0] count;
    logic [1:0] count_next;
    logic       push;
    logic       pop;

    logic [WIDTH-1:0] dec_in1;
    logic [WIDTH-1:0] dec_in2;
    logic             dec_cin;

    assign in_ready = (count != FULL);
    assign push     = in_valid && in_ready;
    assign pop      = out_valid && out_ready;

    always_comb begin
        dec_in1 = in_a;
        dec_in2 = in_b;
        dec_cin = 1'b0;
        case (op_e'(in_op))
            OP_ADD: begin
                dec_in1 = in_a;
                dec_in2 = in_b;
                dec_cin = 1'b0;
            end
            OP_SUB: begin
                dec_in1 = in_a;
                dec_in2 = ~in_b;
                dec_cin = 1'b1;
            end
            OP_INC: begin
                dec_in1 = in_a;
                dec_in2 = '0;
                dec_cin = 1'b1;
            end
            OP_NEG: begin
                dec_in1 = '0;
                dec_in2 = ~in_b;
                dec_cin = 1'b1;
            end
            default: ;
        endcase
    end

    always_comb begin
        count_next = count + {1'b0, push} - {1'b0, pop};
    end

    // Storage needs no reset: count gates every read.
    always_ff @(posedge clock) begin
        if (push) begin
            mem_in1[tail] <= dec_in1;
            mem_in2[tail] <= dec_in2;
            mem_cin[tail] <= dec_cin;
            mem_op[tail]  <= in_op;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            head      <= 1'b0;
            tail      <= 1'b0;
            count     <= 2'd0;
            out_valid <= 1'b0;
            add_in1   <= '0;
            add_in2   <= '0;
            add_cin   <= 1'b0;
            out_op    <= 2'b00;
            op_count  <= 16'd0;
        end else begin
            if (push) tail <= ~tail;
            if (pop) begin
                head     <= ~head;
                op_count <= op_count + 16'd1;
            end
            count     <= count_next;
            out_valid <= (count_next != 2'd0);
            // Head registers load whichever entry becomes the head next; they hold when the buffer drains.
            if (push && (count == 2'd0 || (count == 2'd1 && pop))) begin
                add_in1 <= dec_in1;
                add_in2 <= dec_in2;
                add_cin <= dec_cin;
                out_op  <= in_op;
            end else if (pop && count == FULL) begin
                add_in1 <= mem_in1[~head];
                add_in2 <= mem_in2[~head];
                add_cin <= mem_cin[~head];
                out_op  <= mem_op[~head];
            end
        end
    end

`ifdef ADDSUB_STALL_STATS_EN
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            stall_count <= 16'd0;
        end else if (out_valid && !out_ready && stall_count != 16'hFFFF) begin
            stall_count <= stall_count + 16'd1;
        end
    end
`endif

endmodule
